// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding and sizing helpers for the PE-grid sequencer
package systolic_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CLEAR  = 3'd1;
    localparam state_t ST_FEED   = 3'd2;
    localparam state_t ST_SETTLE = 3'd3;
    localparam state_t ST_DRAIN  = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

    // PE input register plus accumulator register
    localparam int SETTLE_CYC = 2;

    // Bits needed to hold the longest feed phase: K_max + 2*(N-1)
    function automatic int step_w_min(input int k_w, input int n);
        return $clog2((1 << k_w) + 2 * (n - 1));
    endfunction

endpackage

// File: rtl/systolic_if.sv
// rtl/systolic_if.sv - job request and PE-grid control bundle for systolic_ctrl
interface systolic_if #(
    parameter int N      = 4,
    parameter int K_W    = 8,
    parameter int STEP_W = 10
);
    logic                 i_start;
    logic                 i_abort;
    logic [K_W-1:0]       i_k_len;
    logic                 i_mode;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_sync;
    logic                 o_en;
    logic                 o_mode;
    logic [N-1:0]         o_a_valid;
    logic [N-1:0]         o_b_valid;
    logic [STEP_W-1:0]    o_step;
    logic                 o_drain_valid;
    logic [$clog2(N)-1:0] o_drain_row;

    modport master (
        input  i_start, i_abort, i_k_len, i_mode,
        output o_busy, o_done, o_sync, o_en, o_mode, o_a_valid, o_b_valid,
               o_step, o_drain_valid, o_drain_row
    );

    modport slave (
        output i_start, i_abort, i_k_len, i_mode,
        input  o_busy, o_done, o_sync, o_en, o_mode, o_a_valid, o_b_valid,
               o_step, o_drain_valid, o_drain_row
    );
endinterface

// File: rtl/systolic_valid_gen.sv
// rtl/systolic_valid_gen.sv - per-row/col feed windows; SYSTOLIC_SKEW_EN selects skewed vs broadcast
module systolic_valid_gen #(
    parameter int N      = 4,
    parameter int K_W    = 8,
    parameter int STEP_W = 10
) (
    input  logic              i_feed,
    input  logic [STEP_W-1:0] i_step,
    input  logic [K_W-1:0]    i_k_len,
    output logic [N-1:0]      o_a_valid,
    output logic [N-1:0]      o_b_valid
);
`ifdef SYSTOLIC_SKEW_EN
    localparam int SKEW = 1;
`else
    localparam int SKEW = 0;
`endif

    logic [STEP_W:0] t_ext;
    logic [STEP_W:0] k_ext;

    assign t_ext = {1'b0, i_step};
    assign k_ext = (STEP_W + 1)'(i_k_len);

    // Broadcast is the zero-offset case: every lane's window is [0, K), i.e. all of FEED
    for (genvar r = 0; r < N; r++) begin : g_lane
        localparam logic [STEP_W:0] OFF = (STEP_W + 1)'(r * SKEW);
        assign o_a_valid[r] = i_feed && (t_ext >= OFF) && (t_ext < OFF + k_ext);
    end

    assign o_b_valid = o_a_valid;

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - job sequencer for the N x N PE grid (SYSTOLIC_SKEW_EN: skewed feed)
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int N      = 4,
    parameter int K_W    = 8,
    parameter int STEP_W = 10
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    systolic_if.master bus
);
    localparam int DR_W = $clog2(N);
    localparam int F_W  = step_w_min(K_W, N);
    localparam int CW   = (F_W > STEP_W) ? F_W : STEP_W;

    state_t            state_q, state_d;
    logic [K_W-1:0]    k_q;
    logic              mode_q;
    logic [STEP_W-1:0] step_q;
    logic [DR_W-1:0]   cnt_q;
    logic [CW-1:0]     f_len;
    logic              feed_last, settle_last, drain_last;
    logic              busy, done, sync, en, feed, drain_v;

`ifdef SYSTOLIC_SKEW_EN
    assign f_len = CW'(k_q) + CW'(2 * (N - 1));
`else
    assign f_len = CW'(k_q);
`endif

    assign feed_last   = (CW'(step_q) == f_len - CW'(1));
    assign settle_last = (cnt_q == DR_W'(SETTLE_CYC - 1));
    assign drain_last  = (cnt_q == DR_W'(N - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.i_start) state_d = ST_CLEAR;
            ST_CLEAR:  state_d = (f_len == '0) ? ST_SETTLE : ST_FEED;
            ST_FEED:   if (feed_last)   state_d = ST_SETTLE;
            ST_SETTLE: if (settle_last) state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_last)  state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
        if (bus.i_abort && state_q != ST_IDLE) state_d = ST_IDLE;
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        sync    = 1'b0;
        en      = 1'b0;
        feed    = 1'b0;
        drain_v = 1'b0;
        case (state_q)
            ST_CLEAR:  begin busy = 1'b1; sync = 1'b1; en = 1'b1; end
            ST_FEED:   begin busy = 1'b1; en = 1'b1; feed = 1'b1; end
            ST_SETTLE: begin busy = 1'b1; en = 1'b1; end
            ST_DRAIN:  begin busy = 1'b1; en = 1'b1; drain_v = 1'b1; end
            ST_DONE:   begin busy = 1'b1; done = 1'b1; end
            default:   ;
        endcase
    end

    // Counters restart whenever the state changes, so each phase begins at 0
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            k_q    <= '0;
            mode_q <= 1'b0;
            step_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (state_q == ST_IDLE && bus.i_start) begin
                k_q    <= bus.i_k_len;
                mode_q <= bus.i_mode;
            end
            step_q <= (state_q == ST_FEED && state_d == ST_FEED) ? step_q + STEP_W'(1) : '0;
            cnt_q  <= (state_d == state_q && (state_q == ST_SETTLE || state_q == ST_DRAIN))
                      ? cnt_q + DR_W'(1) : '0;
        end
    end

    systolic_valid_gen #(.N(N), .K_W(K_W), .STEP_W(STEP_W)) u_valid_gen (
        .i_feed    (feed),
        .i_step    (step_q),
        .i_k_len   (k_q),
        .o_a_valid (bus.o_a_valid),
        .o_b_valid (bus.o_b_valid)
    );

    assign bus.o_busy        = busy;
    assign bus.o_done        = done;
    assign bus.o_sync        = sync;
    assign bus.o_en          = en;
    assign bus.o_mode        = busy & mode_q;
    assign bus.o_step        = feed ? step_q : '0;
    assign bus.o_drain_valid = drain_v;
    assign bus.o_drain_row   = drain_v ? cnt_q : '0;

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - directed bench for systolic_ctrl (expectations follow SYSTOLIC_SKEW_EN)
module tb_systolic_ctrl;
    localparam int N      = 4;
    localparam int K_W    = 8;
    localparam int STEP_W = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_if #(.N(N), .K_W(K_W), .STEP_W(STEP_W)) bus ();

    systolic_ctrl #(.N(N), .K_W(K_W), .STEP_W(STEP_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.master)
    );

    logic [25:0] outs;
    assign outs = {bus.o_busy, bus.o_done, bus.o_sync, bus.o_en, bus.o_mode, bus.o_a_valid,
                   bus.o_b_valid, bus.o_step, bus.o_drain_valid, bus.o_drain_row};

    typedef struct {
        int k;
        int mode;
        int exp_f;
        int exp_busy;
        int exp_row2_cnt;
        int exp_row2_first;
    } job_t;

    job_t jobs[6];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int idx, input job_t j);
        int busy_len = 0, sync_cnt = 0, en_cnt = 0, mode_err = 0;
        int row2_cnt = 0, row2_first = -1, vcnt = 0, step_err = 0;
        int first_drain = -1, drain_seen = 0, drain_err = 0, done_idx = -1;
        int exp_step;
        bus.i_k_len = K_W'(j.k);
        bus.i_mode  = j.mode[0];
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        bus.i_k_len = ~K_W'(j.k);
        bus.i_mode  = ~j.mode[0];
        for (int c = 0; c < 60; c++) begin
            if (bus.o_busy) busy_len++;
            if (bus.o_sync) sync_cnt++;
            if (bus.o_en) en_cnt++;
            if (bus.o_busy && bus.o_mode !== j.mode[0]) mode_err++;
            if (bus.o_a_valid[2]) begin
                if (row2_first < 0) row2_first = int'(bus.o_step);
                row2_cnt++;
            end
            vcnt += $countones(bus.o_a_valid) + $countones(bus.o_b_valid);
            exp_step = (c >= 1 && c <= j.exp_f) ? c - 1 : 0;
            if (int'(bus.o_step) != exp_step) step_err++;
            if (bus.o_drain_valid) begin
                if (first_drain < 0) first_drain = c;
                if (int'(bus.o_drain_row) != drain_seen) drain_err++;
                drain_seen++;
            end
            if (bus.o_done) begin
                done_idx = c;
                break;
            end
            tick();
        end
        check($sformatf("job%0d_done_idx", idx), done_idx, j.exp_f + 7);
        check($sformatf("job%0d_busy_len", idx), busy_len, j.exp_busy);
        check($sformatf("job%0d_sync_cnt", idx), sync_cnt, 1);
        check($sformatf("job%0d_en_cnt", idx), en_cnt, j.exp_busy - 1);
        check($sformatf("job%0d_mode_err", idx), mode_err, 0);
        check($sformatf("job%0d_row2_cnt", idx), row2_cnt, j.exp_row2_cnt);
        check($sformatf("job%0d_row2_first", idx), row2_first, j.exp_row2_first);
        check($sformatf("job%0d_valid_total", idx), vcnt, 2 * N * j.k);
        check($sformatf("job%0d_step_err", idx), step_err, 0);
        check($sformatf("job%0d_first_drain", idx), first_drain, j.exp_f + 3);
        check($sformatf("job%0d_drain_rows", idx), drain_seen, N);
        check($sformatf("job%0d_drain_order", idx), drain_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
`ifdef SYSTOLIC_SKEW_EN
        jobs[0] = '{3, 0,  9, 17, 3,  2};
        jobs[1] = '{5, 1, 11, 19, 5,  2};
        jobs[2] = '{0, 1,  6, 14, 0, -1};
        jobs[3] = '{1, 0,  7, 15, 1,  2};
        jobs[4] = '{2, 0,  8, 16, 2,  2};
        jobs[5] = '{7, 1, 13, 21, 7,  2};
`else
        jobs[0] = '{3, 0,  3, 11, 3,  0};
        jobs[1] = '{5, 1,  5, 13, 5,  0};
        jobs[2] = '{0, 1,  0,  8, 0, -1};
        jobs[3] = '{1, 0,  1,  9, 1,  0};
        jobs[4] = '{2, 0,  2, 10, 2,  0};
        jobs[5] = '{7, 1,  7, 15, 7,  0};
`endif
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_k_len = '0;
        bus.i_mode  = 1'b0;
        tick();
        tick();
        check("reset_outs", 32'(outs), 0);
        rst_n = 1'b1;
        tick();
        check("idle_outs", 32'(outs), 0);

        for (int i = 0; i < 6; i++) begin
            run_job(i, jobs[i]);
            tick();
            check($sformatf("job%0d_idle_after", i), 32'(outs), 0);
        end

        // start presented in the DONE cycle is ignored
        run_job(6, jobs[0]);
        bus.i_start = 1'b1;
        tick();
        check("done_start_busy0", 32'(bus.o_busy), 0);
        bus.i_start = 1'b0;
        tick();
        check("done_start_busy1", 32'(bus.o_busy), 0);

        // abort at FEED t=2, then immediate restart
        bus.i_k_len = 8'd3;
        bus.i_mode  = 1'b1;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        n = 0;
        while (bus.o_step != 2 && n < 20) begin
            tick();
            n++;
        end
        check("abort_reach_t2", 32'(n < 20), 1);
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        check("abort_outs", 32'(outs), 0);
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check("restart_busy_sync", 32'({bus.o_busy, bus.o_sync, bus.o_done}), 32'b110);
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        check("abort_clear_outs", 32'(outs), 0);

        // reset mid-DRAIN with start held through reset
        bus.i_k_len = 8'd2;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        n = 0;
        while (!bus.o_drain_valid && n < 30) begin
            tick();
            n++;
        end
        check("reach_drain", 32'(n < 30), 1);
        rst_n       = 1'b0;
        bus.i_start = 1'b1;
        tick();
        check("rst_drain_outs0", 32'(outs), 0);
        tick();
        check("rst_drain_outs1", 32'(outs), 0);
        rst_n = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check("post_rst_start", 32'({bus.o_busy, bus.o_sync}), 32'b11);
        bus.i_abort = 1'b1;
        tick();
        check("abort_post_rst", 32'(outs), 0);

        // abort alone in IDLE does nothing; with start, start wins
        tick();
        check("idle_abort_outs", 32'(outs), 0);
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check("start_beats_abort", 32'({bus.o_busy, bus.o_sync}), 32'b11);
        tick();
        check("abort_in_clear", 32'(outs), 0);
        bus.i_abort = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
